serial_adder_ctrl: RTL and testbench

//  Sequencer around the 2-bit adder netlist slice (adder_2bit): adds two WIDTH-bit operands
//  two bits per cycle, LSB pair first, by driving the slice inputs and consuming its outputs.

---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/adder_2bit.sv | 20 ++
 rtl/serial_adder_ctrl.sv | 124 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the serial adder sequencer.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits consumed per cycle by the adder slice.
    localparam int SLICE_W = 2;

    // Number of slice steps needed for an operand of the given width.
    function automatic int steps(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/adder_2bit.sv
// Two-bit ripple adder slice driven by serial_adder_ctrl through its slice_* ports.
module adder_2bit (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       cin,
    output logic [1:0] sum,
    output logic       cout
);

    logic c1;

    // Two chained full adders, LSB first.
    always_comb begin
        sum[0] = a[0] ^ b[0] ^ cin;
        c1     = (a[0] & b[0]) | (a[0] & cin) | (b[0] & cin);
        sum[1] = a[1] ^ b[1] ^ c1;
        cout   = (a[1] & b[1]) | (a[1] & c1) | (b[1] & c1);
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Sequencer that adds two WIDTH-bit operands two bits per cycle through an
// external adder_2bit slice, LSB pair first, with the slice carry fed back.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic [1:0]       slice_a,
    output logic [1:0]       slice_b,
    output logic             slice_cin,
    input  logic [1:0]       slice_sum,
    input  logic             slice_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    localparam int STEPS = steps(WIDTH);
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    generate
        if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_width_check
            $error("serial_adder_ctrl: WIDTH must be even and >= 2");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] step_q, step_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    assign out_sum  = sum_q;
    assign out_cout = cout_q;

    // Next-state, datapath updates and handshake/slice outputs.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        carry_d   = carry_q;
        step_d    = step_q;
        acc_d     = acc_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        slice_a   = '0;
        slice_b   = '0;
        slice_cin = 1'b0;
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    step_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Operands shift right so the current pair always sits in bits [1:0];
                // slice results are only sampled here, keeping X off the state when idle.
                slice_a   = a_q[1:0];
                slice_b   = b_q[1:0];
                slice_cin = carry_q;
                a_d       = a_q >> SLICE_W;
                b_d       = b_q >> SLICE_W;
                carry_d   = slice_cout;
                acc_d[SLICE_W*int'(step_q) +: SLICE_W] = slice_sum;
                step_d    = step_q + CNT_W'(1);
                if (step_q == LAST_STEP) begin
                    sum_d   = acc_d;
                    cout_d  = slice_cout;
                    step_d  = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            step_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl wrapped around an adder_2bit slice.
module tb_serial_adder_ctrl;

    localparam int W     = 8;
    localparam int STEPS = W / 2;
    localparam int NOPS  = 1000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic [1:0]   slice_a;
    logic [1:0]   slice_b;
    logic         slice_cin;
    logic [1:0]   slice_sum;
    logic         slice_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;

    int checks = 0;
    int errors = 0;

    serial_adder_ctrl #(.WIDTH(W)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_cin     (in_cin),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_sum  (slice_sum),
        .slice_cout (slice_cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_cout   (out_cout)
    );

    adder_2bit u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (slice_cin),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: full-width sum plus carry-in as plain integer arithmetic.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic ci);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    endfunction

    // Offer one operand pair from IDLE, check slice traffic per step and latency,
    // and return at the first negedge where out_valid is high (no handshake yet).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input string tag);
        logic [W:0] exp;
        int n;
        int k;
        int mask;
        exp = model(a, b, ci);
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = ci;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            k = n - 1;
            if (k < STEPS) begin
                mask = (1 << (2 * k)) - 1;
                check({tag, " slice_a"}, 32'(slice_a), (int'(a) >> (2 * k)) & 3);
                check({tag, " slice_b"}, 32'(slice_b), (int'(b) >> (2 * k)) & 3);
                check({tag, " slice_cin"}, 32'(slice_cin),
                      (((int'(a) & mask) + (int'(b) & mask) + int'(ci)) >> (2 * k)) & 1);
            end
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(STEPS + 1));
        check({tag, " out_sum"}, 32'(out_sum), 32'(exp[W-1:0]));
        check({tag, " out_cout"}, 32'(out_cout), 32'(exp[W]));
        check({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
        check({tag, " slice idle"}, {27'd0, slice_a, slice_b, slice_cin}, 32'd0);
    endtask

    // Complete the handshake (out_ready already high) and check the return to IDLE.
    task automatic finish_op(input logic [W-1:0] exp_sum, input string tag);
        @(negedge clk);
        check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready back"}, 32'(in_ready), 32'd1);
        check({tag, " sum kept"}, 32'(out_sum), 32'(exp_sum));
    endtask

    initial begin
        logic [W:0] expq[$];
        logic [W:0] e;
        logic       took;
        int         sent;
        int         got;
        int         cyc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_sum", 32'(out_sum), 32'd0);
        check("rst out_cout", 32'(out_cout), 32'd0);
        check("rst slice", {27'd0, slice_a, slice_b, slice_cin}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed arithmetic cases
        run_op(8'h5A, 8'h3C, 1'b0, "t1");
        finish_op(8'h96, "t1");
        run_op(8'hFF, 8'h01, 1'b0, "t2");
        finish_op(8'h00, "t2");
        run_op(8'hFF, 8'hFF, 1'b1, "t3a");
        finish_op(8'hFF, "t3a");
        run_op(8'h00, 8'h00, 1'b1, "t3b");
        finish_op(8'h01, "t3b");

        // Backpressure: result held, new operands refused until the handshake
        out_ready = 1'b0;
        run_op(8'h5A, 8'h3C, 1'b0, "t4");
        in_valid = 1'b1;
        in_a     = 8'h11;
        in_b     = 8'h22;
        in_cin   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4 hold valid", 32'(out_valid), 32'd1);
            check("t4 hold sum", 32'(out_sum), 32'h96);
            check("t4 hold in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t4 hs valid", 32'(out_valid), 32'd0);
        check("t4 hs in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        run_op(8'h11, 8'h22, 1'b0, "t4b");
        finish_op(8'h33, "t4b");

        // Reset during step 2 aborts the operation
        in_valid = 1'b1;
        in_a     = 8'h12;
        in_b     = 8'h34;
        in_cin   = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("t5 step2 slice_a", 32'(slice_a), 32'd1);
        check("t5 step2 slice_b", 32'(slice_b), 32'd3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t5 in_ready", 32'(in_ready), 32'd1);
        check("t5 out_valid", 32'(out_valid), 32'd0);
        check("t5 slice", {27'd0, slice_a, slice_b, slice_cin}, 32'd0);
        check("t5 out_sum", 32'(out_sum), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t5 no result", 32'(out_valid), 32'd0);
        end
        run_op(8'h01, 8'h01, 1'b0, "t5b");
        finish_op(8'h02, "t5b");

        // Randomized back-to-back traffic against the reference model
        sent = 0;
        got  = 0;
        cyc  = 0;
        took = 1'b0;
        while (got < NOPS && cyc < 40000) begin
            if (took) begin
                in_valid = 1'b0;
            end
            if (!in_valid && sent < NOPS && $urandom_range(3) != 0) begin
                in_valid = 1'b1;
                in_a     = W'($urandom);
                in_b     = W'($urandom);
                in_cin   = 1'($urandom_range(1));
            end
            out_ready = ($urandom_range(3) != 0);
            took = in_valid && in_ready;
            if (took) begin
                expq.push_back(model(in_a, in_b, in_cin));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check("rand spurious result", 32'(out_valid), 32'd0);
                end else begin
                    e = expq.pop_front();
                    check("rand result", 32'({out_cout, out_sum}), 32'(e));
                    got++;
                end
            end
            if (in_ready || out_valid) begin
                check("rand slice idle", {27'd0, slice_a, slice_b, slice_cin}, 32'd0);
            end
            @(negedge clk);
            cyc++;
        end
        check("rand result count", 32'(got), 32'(NOPS));
        check("rand leftover", 32'(expq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
